// File: rtl/fma_pkg.sv
// Shared definitions for the FMA special-case pipeline: operand classes,
// exception flag bit positions and the FP16 default field widths.
package fma_pkg;

  localparam int FP16_EXP_W = 5;
  localparam int FP16_MAN_W = 10;

  // Bit positions inside the 4-bit flags vector {NV, OF, UF, NX}
  localparam int FLAG_NV = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;

  typedef enum logic [2:0] {
    FP_ZERO = 3'd0,
    FP_SUB  = 3'd1,
    FP_NORM = 3'd2,
    FP_INF  = 3'd3,
    FP_QNAN = 3'd4,
    FP_SNAN = 3'd5
  } fp_class_t;

endpackage

// File: rtl/fp_classify.sv
// Combinational operand classifier. Looks only at the exponent and
// mantissa fields; the sign never changes the class.
module fp_classify
  import fma_pkg::*;
#(
  parameter int EXP_W = FP16_EXP_W,
  parameter int MAN_W = FP16_MAN_W
) (
  input  logic [EXP_W+MAN_W-1:0] magn,
  output fp_class_t              cls
);

  logic [EXP_W-1:0] expField;
  logic [MAN_W-1:0] manField;

  assign expField = magn[EXP_W+MAN_W-1:MAN_W];
  assign manField = magn[MAN_W-1:0];

  // Decode the class from the exponent/mantissa field pattern
  always_comb begin
    cls = FP_NORM;
    if (expField == '0) begin
      if (manField == '0) cls = FP_ZERO;
      else                cls = FP_SUB;
    end else if (&expField) begin
      if (manField == '0)          cls = FP_INF;
      else if (manField[MAN_W-1])  cls = FP_QNAN;
      else                         cls = FP_SNAN;
    end
  end

endmodule

// File: rtl/fma_special_pipe.sv
// Two-stage FMA special-case resolver. Stage 1 classifies and registers the
// operands together with the datapath product/sum; stage 2 picks the final
// result and exception flags. Valid/ready handshakes on both sides.
// Optional feature: define FMA_STICKY_FLAGS_EN to get an accumulating
// sticky flag register with a clear input; otherwise sticky_flags is 0.
module fma_special_pipe
  import fma_pkg::*;
#(
  parameter int EXP_W = FP16_EXP_W,
  parameter int MAN_W = FP16_MAN_W,
  localparam int W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic [W-1:0] z,
  input  logic [W-1:0] product,
  input  logic [W-1:0] sum,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         special,
  output logic [3:0]   flags,
  input  logic         flags_clr,
  output logic [3:0]   sticky_flags
);

  localparam logic [W-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic signed [EXP_W+1:0] BIAS_S = $signed({3'b000, {(EXP_W-1){1'b1}}});
  localparam logic signed [EXP_W+1:0] ONE_S  = $signed({{(EXP_W+1){1'b0}}, 1'b1});

  // Rule-ordered special-case resolution; returns {special, flags, result}.
  function automatic logic [W+4:0] resolveOp(
    input fp_class_t        cX,
    input fp_class_t        cY,
    input fp_class_t        cZ,
    input logic             sX,
    input logic             sY,
    input logic [EXP_W-1:0] eX,
    input logic [EXP_W-1:0] eY,
    input logic [W-1:0]     zV,
    input logic             sP,
    input logic [EXP_W-1:0] eP,
    input logic [W-1:0]     sumV
  );
    logic                    nanAny;
    logic                    snanAny;
    logic                    infX;
    logic                    infY;
    logic                    zeroX;
    logic                    zeroY;
    logic                    finX;
    logic                    finY;
    logic                    signP;
    logic signed [EXP_W+1:0] expSum;
    logic [W-1:0]            res;
    logic                    spec;
    logic [3:0]              flg;

    nanAny  = (cX == FP_QNAN) || (cX == FP_SNAN) || (cY == FP_QNAN) ||
              (cY == FP_SNAN) || (cZ == FP_QNAN) || (cZ == FP_SNAN);
    snanAny = (cX == FP_SNAN) || (cY == FP_SNAN) || (cZ == FP_SNAN);
    infX    = (cX == FP_INF);
    infY    = (cY == FP_INF);
    zeroX   = (cX == FP_ZERO);
    zeroY   = (cY == FP_ZERO);
    finX    = (cX == FP_SUB) || (cX == FP_NORM);
    finY    = (cY == FP_SUB) || (cY == FP_NORM);
    signP   = sX ^ sY;
    // Widened signed sum so large exponents cannot wrap into the UF test
    expSum  = $signed({2'b00, eX}) + $signed({2'b00, eY}) - BIAS_S;

    res  = sumV;
    spec = 1'b1;
    flg  = 4'b0000;

    if (nanAny) begin
      res          = CANON_NAN;
      flg[FLAG_NV] = snanAny;
    end else if ((zeroX && infY) || (infX && zeroY)) begin
      res          = CANON_NAN;
      flg[FLAG_NV] = 1'b1;
    end else if ((infX || infY) && (cZ == FP_INF) && (zV[W-1] != signP)) begin
      res          = CANON_NAN;
      flg[FLAG_NV] = 1'b1;
    end else if (infX || infY) begin
      res = {signP, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (cZ == FP_INF) begin
      res = zV;
    end else if (&eP) begin
      res          = {sP, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLAG_OF] = 1'b1;
      flg[FLAG_NX] = 1'b1;
    end else if (&sumV[W-2:MAN_W]) begin
      res          = {sumV[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      flg[FLAG_OF] = 1'b1;
      flg[FLAG_NX] = 1'b1;
    end else if (finX && finY && (expSum < ONE_S) && (cZ != FP_ZERO)) begin
      res          = zV;
      flg[FLAG_UF] = 1'b1;
      flg[FLAG_NX] = 1'b1;
    end else begin
      res  = sumV;
      spec = 1'b0;
    end
    return {spec, flg, res};
  endfunction

  fp_class_t clsX;
  fp_class_t clsY;
  fp_class_t clsZ;

  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uClassX (.magn(x[W-2:0]), .cls(clsX));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uClassY (.magn(y[W-2:0]), .cls(clsY));
  fp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W)) uClassZ (.magn(z[W-2:0]), .cls(clsZ));

  // Only sign and exponent of the product matter for overflow detection
  logic [MAN_W-1:0] unusedProdMan;
  assign unusedProdMan = product[MAN_W-1:0];

  logic             vld_p1;
  logic             vld_p2;
  logic             adv2;
  logic             outXfer;
  fp_class_t        clsX_p1;
  fp_class_t        clsY_p1;
  fp_class_t        clsZ_p1;
  logic             signX_p1;
  logic             signY_p1;
  logic [EXP_W-1:0] expX_p1;
  logic [EXP_W-1:0] expY_p1;
  logic [W-1:0]     z_p1;
  logic             signProd_p1;
  logic [EXP_W-1:0] expProd_p1;
  logic [W-1:0]     sum_p1;
  logic [W+4:0]     resolved;
  logic [W-1:0]     result_p2;
  logic             special_p2;
  logic [3:0]       flags_p2;

  assign adv2     = !vld_p2 || out_ready;
  assign in_ready = !vld_p1 || adv2;
  assign outXfer  = vld_p2 && out_ready;

  // Stage 1 valid: refills whenever the stage can accept
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      vld_p1 <= 1'b0;
    else if (in_ready) vld_p1 <= in_valid;
  end

  // Stage 1 data: operand classes and fields captured on acceptance
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) begin
      clsX_p1     <= clsX;
      clsY_p1     <= clsY;
      clsZ_p1     <= clsZ;
      signX_p1    <= x[W-1];
      signY_p1    <= y[W-1];
      expX_p1     <= x[W-2:MAN_W];
      expY_p1     <= y[W-2:MAN_W];
      z_p1        <= z;
      signProd_p1 <= product[W-1];
      expProd_p1  <= product[W-2:MAN_W];
      sum_p1      <= sum;
    end
  end

  // Resolve the registered operands into {special, flags, result}
  always_comb begin
    resolved = resolveOp(clsX_p1, clsY_p1, clsZ_p1, signX_p1, signY_p1,
                         expX_p1, expY_p1, z_p1, signProd_p1, expProd_p1, sum_p1);
  end

  // Stage 2 valid: advances when the output slot is empty or draining
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  vld_p2 <= 1'b0;
    else if (adv2) vld_p2 <= vld_p1;
  end

  // Stage 2 data: load on advance, otherwise hold steady while stalled
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      result_p2  <= '0;
      special_p2 <= 1'b0;
      flags_p2   <= 4'b0000;
    end else if (vld_p1 && adv2) begin
      special_p2 <= resolved[W+4];
      flags_p2   <= resolved[W+3:W];
      result_p2  <= resolved[W-1:0];
    end
  end

  assign out_valid = vld_p2;
  assign result    = result_p2;
  assign special   = special_p2;
  assign flags     = flags_p2;

`ifdef FMA_STICKY_FLAGS_EN
  logic [3:0] stickyQ;

  // Accumulate flags of each delivered result; a clear keeps only the
  // flags of a transfer happening in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       stickyQ <= 4'b0000;
    else if (flags_clr) stickyQ <= outXfer ? flags_p2 : 4'b0000;
    else if (outXfer)   stickyQ <= stickyQ | flags_p2;
  end

  assign sticky_flags = stickyQ;
`else
  logic unusedFlagsClr;
  logic unusedXfer;
  assign unusedFlagsClr = flags_clr;
  assign unusedXfer     = outXfer;
  assign sticky_flags   = 4'b0000;
`endif

endmodule
